// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out a change amount one coin per clock, largest
// denomination first, drawing on its own registered coin inventory.
module change_dispenser #(
    parameter int AMT_W   = 4,
    parameter int CNT_W   = 2,
    parameter int DEN_HI  = 5,
    parameter int DEN_MID = 3,
    parameter int DEN_LO  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             load_inv,
    input  logic [CNT_W-1:0] pent_init,
    input  logic [CNT_W-1:0] tri_init,
    input  logic [CNT_W-1:0] cir_init,
    output logic             busy,
    output logic             coin_valid,
    output logic [AMT_W-1:0] coin,
    output logic [AMT_W-1:0] remaining,
    output logic             done,
    output logic             short,
    output logic [CNT_W-1:0] pent_left,
    output logic [CNT_W-1:0] tri_left,
    output logic [CNT_W-1:0] cir_left
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPENSE,
        S_DONE
    } state_t;

    // Slot 0 is the pentagon, so a lower index means higher dispensing priority.
    localparam logic [2:0][AMT_W-1:0] L_DEN = {AMT_W'(DEN_LO), AMT_W'(DEN_MID), AMT_W'(DEN_HI)};

    state_t             r_state;
    logic [AMT_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_coin_valid;
    logic [AMT_W-1:0]   r_coin;
    logic               r_done;
    logic               r_short;

    logic [2:0][CNT_W-1:0] w_init;
    logic [2:0][CNT_W-1:0] w_inv;
    logic [2:0]            w_elig;
    logic [2:0]            w_pick;
    logic [AMT_W-1:0]      w_coin_val;

    assign w_init = {cir_init, tri_init, pent_init};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inv
            logic [CNT_W-1:0] r_cnt;

            assign w_elig[gi] = (r_rem >= L_DEN[gi]) && (r_cnt != '0);
            assign w_inv[gi]  = r_cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (r_state == S_IDLE && load_inv) begin
                    r_cnt <= w_init[gi];
                end else if (r_state == S_DISPENSE && w_pick[gi]) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    endgenerate

    // Fixed-priority pick of the first eligible denomination.
    always_comb begin
        w_pick     = '0;
        w_coin_val = '0;
        if (w_elig[0]) begin
            w_pick[0]  = 1'b1;
            w_coin_val = L_DEN[0];
        end else if (w_elig[1]) begin
            w_pick[1]  = 1'b1;
            w_coin_val = L_DEN[1];
        end else if (w_elig[2]) begin
            w_pick[2]  = 1'b1;
            w_coin_val = L_DEN[2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_busy       <= 1'b0;
            r_coin_valid <= 1'b0;
            r_coin       <= '0;
            r_done       <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_coin_valid <= 1'b0;
            r_coin       <= '0;
            case (r_state)
                S_IDLE: begin
                    // A simultaneous inventory load takes precedence over start.
                    if (!load_inv && start) begin
                        r_rem   <= amount;
                        r_short <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (r_rem == '0) begin
                        r_short <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_pick != '0) begin
                        r_coin_valid <= 1'b1;
                        r_coin       <= w_coin_val;
                        r_rem        <= r_rem - w_coin_val;
                    end else begin
                        r_short <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign coin_valid = r_coin_valid;
    assign coin       = r_coin;
    assign remaining  = r_rem;
    assign done       = r_done;
    assign short      = r_short;
    assign pent_left  = w_inv[0];
    assign tri_left   = w_inv[1];
    assign cir_left   = w_inv[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy inventory model queues the
// expected coins per request and the monitor pops them as coins appear.
module tb_change_dispenser;

    localparam int AMT_W = 4;
    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             load_inv = 1'b0;
    logic [CNT_W-1:0] pent_init = '0;
    logic [CNT_W-1:0] tri_init = '0;
    logic [CNT_W-1:0] cir_init = '0;
    logic             busy;
    logic             coin_valid;
    logic [AMT_W-1:0] coin;
    logic [AMT_W-1:0] remaining;
    logic             done;
    logic             short;
    logic [CNT_W-1:0] pent_left;
    logic [CNT_W-1:0] tri_left;
    logic [CNT_W-1:0] cir_left;

    change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .DEN_HI(5), .DEN_MID(3), .DEN_LO(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .amount(amount),
        .load_inv(load_inv), .pent_init(pent_init), .tri_init(tri_init),
        .cir_init(cir_init), .busy(busy), .coin_valid(coin_valid), .coin(coin),
        .remaining(remaining), .done(done), .short(short),
        .pent_left(pent_left), .tri_left(tri_left), .cir_left(cir_left)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int m_inv [3];
    int exp_coin_q [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_inv(input string tag);
        chk({tag, "_pent"}, int'(pent_left), m_inv[0]);
        chk({tag, "_tri"},  int'(tri_left),  m_inv[1]);
        chk({tag, "_cir"},  int'(cir_left),  m_inv[2]);
    endtask

    task automatic load(input int p, input int t, input int c);
        @(negedge clock);
        load_inv  = 1'b1;
        pent_init = CNT_W'(p);
        tri_init  = CNT_W'(t);
        cir_init  = CNT_W'(c);
        @(negedge clock);
        load_inv = 1'b0;
        m_inv[0] = p; m_inv[1] = t; m_inv[2] = c;
        $display("load pent=%0d tri=%0d cir=%0d", p, t, c);
        chk_inv("load");
    endtask

    // inject: fire start+load_inv mid-dispense; abort: reset after first coin.
    task automatic run_txn(input int amt, input bit inject, input bit abort);
        int  rem;
        int  ncoins;
        int  popped;
        bit  exp_short;
        bit  seen_done;
        bit  more;
        int  den [3];
        den[0] = 5; den[1] = 3; den[2] = 1;
        rem = amt;
        exp_coin_q.delete();
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!more && rem >= den[k] && m_inv[k] > 0) begin
                    exp_coin_q.push_back(den[k]);
                    rem = rem - den[k];
                    m_inv[k] = m_inv[k] - 1;
                    more = 1'b1;
                end
            end
        end
        exp_short = (rem != 0);
        ncoins    = exp_coin_q.size();

        @(negedge clock);
        start  = 1'b1;
        amount = AMT_W'(amt);
        @(negedge clock);
        start  = 1'b0;
        popped = 0;
        seen_done = 1'b0;
        for (int j = 0; j < 40 && !seen_done; j++) begin
            if (j > 0) @(negedge clock);
            if (coin_valid) begin
                if (exp_coin_q.size() > 0) begin
                    chk("coin", int'(coin), exp_coin_q.pop_front());
                    chk("coin_cycle", j, popped + 1);
                    popped++;
                end else begin
                    chk("extra_coin", 1, 0);
                end
            end
            if (!done && j <= ncoins + 1) chk("busy_hi", int'(busy), 1);
            if (done) begin
                seen_done = 1'b1;
                $display("txn amount=%0d coins=%0d short=%0d remaining=%0d at cycle %0d",
                         amt, popped, short, remaining, j);
                chk("done_latency", j, ncoins + 2);
                chk("short", int'(short), int'(exp_short));
                chk("remaining", int'(remaining), rem);
                chk("coins_left_in_queue", exp_coin_q.size(), 0);
                chk("busy_lo", int'(busy), 0);
                chk_inv("after_txn");
            end
            if (inject && j == 1) begin
                start = 1'b1; load_inv = 1'b1; amount = 4'd2;
                pent_init = 2'd3; tri_init = 2'd3; cir_init = 2'd3;
            end else if (inject && j == 2) begin
                start = 1'b0; load_inv = 1'b0;
            end
            if (abort && popped == 1) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                m_inv[0] = 0; m_inv[1] = 0; m_inv[2] = 0;
                exp_coin_q.delete();
                $display("txn amount=%0d aborted by reset after 1 coin", amt);
                chk("abort_busy", int'(busy), 0);
                chk("abort_coin_valid", int'(coin_valid), 0);
                chk("abort_coin", int'(coin), 0);
                chk("abort_remaining", int'(remaining), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_short", int'(short), 0);
                chk_inv("abort");
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    chk("abort_no_done", int'(done), 0);
                end
                return;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        m_inv[0] = 0; m_inv[1] = 0; m_inv[2] = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        $display("reset released");
        chk("rst_busy", int'(busy), 0);
        chk("rst_coin_valid", int'(coin_valid), 0);
        chk("rst_coin", int'(coin), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk_inv("rst");

        // Full payout 5,3,1.
        load(1, 1, 3);
        run_txn(9, 1'b0, 1'b0);
        // Greedy takes 5 and is then stuck at 1 with no circles.
        load(1, 2, 0);
        run_txn(6, 1'b0, 1'b0);
        // Zero amount.
        run_txn(0, 1'b0, 1'b0);
        // Empty inventory, then refill and retry.
        load(0, 0, 0);
        run_txn(4, 1'b0, 1'b0);
        load(0, 0, 3);
        run_txn(3, 1'b0, 1'b0);
        // start/load_inv ignored while dispensing.
        load(1, 1, 1);
        run_txn(9, 1'b1, 1'b0);
        // Same-cycle load and start in IDLE: load wins.
        @(negedge clock);
        load_inv = 1'b1; start = 1'b1; amount = 4'd5;
        pent_init = 2'd2; tri_init = 2'd1; cir_init = 2'd3;
        @(negedge clock);
        load_inv = 1'b0; start = 1'b0;
        m_inv[0] = 2; m_inv[1] = 1; m_inv[2] = 3;
        $display("load+start same cycle");
        for (int k = 0; k < 3; k++) begin
            chk("ls_busy", int'(busy), 0);
            chk("ls_coin_valid", int'(coin_valid), 0);
            @(negedge clock);
        end
        chk_inv("ls");
        // Reset during dispense.
        load(2, 1, 1);
        run_txn(9, 1'b0, 1'b1);
        // Normal operation after the abort.
        load(0, 1, 1);
        run_txn(4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
